// File: rtl/operand_entry_ctrl.sv
// Keypad-to-operand sequencer: BCD entry buffer, dec2bin conversion, valid/ready operand hand-off.
// Optional backspace key (0xD) built only when OPERAND_BACKSPACE_EN is defined.

module operand_entry_dec2bin (
    input  logic [2:0][3:0] bcds_i,
    input  logic            negative_i,
    output logic [9:0]      mag_o,
    output logic [9:0]      value_o
);
    // 3-digit BCD magnitude (max 999 fits in 10 bits) and its signed 10-bit image
    always_comb begin
        mag_o   = 10'(bcds_i[2]) * 10'd100 + 10'(bcds_i[1]) * 10'd10 + 10'(bcds_i[0]);
        value_o = negative_i ? 10'(~mag_o + 10'd1) : mag_o;
    end
endmodule

module operand_entry_ctrl #(
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned CONV_LAT   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            key_valid_i,
    input  logic [3:0]      key_code_i,
    output logic            key_ready_o,
    output logic [2:0][3:0] bcds_o,
    output logic            negative_o,
    output logic [1:0]      digit_cnt_o,
    output logic            op_valid_o,
    input  logic            op_ready_i,
    output logic [9:0]      op_value_o,
    output logic            op_ovf_o,
    output logic            busy_o
);
    localparam int unsigned CNT_W = (CONV_LAT < 2) ? 1 : $clog2(CONV_LAT + 1);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CONV  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0][3:0]   bcds_q, bcds_d;
    logic              negative_q, negative_d;
    logic [1:0]        digit_cnt_q, digit_cnt_d;
    logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;
    logic              op_valid_q, op_valid_d;
    logic [9:0]        op_value_q, op_value_d;
    logic              op_ovf_q, op_ovf_d;
    logic              key_ready_q, key_ready_d;
    logic              busy_q, busy_d;

    logic [9:0]        conv_mag;
    logic [9:0]        conv_value;
    logic              conv_ovf;
    logic              key_fire;

    operand_entry_dec2bin u_dec2bin (
        .bcds_i     (bcds_q),
        .negative_i (negative_q),
        .mag_o      (conv_mag),
        .value_o    (conv_value)
    );

    // Negative range reaches one further than positive (-512..+511)
    assign conv_ovf = (!negative_q && (conv_mag > 10'd511)) ||
                      ( negative_q && (conv_mag > 10'd512));
    assign key_fire = key_valid_i && (state_q == ST_ENTRY);

    always_comb begin
        state_d     = state_q;
        bcds_d      = bcds_q;
        negative_d  = negative_q;
        digit_cnt_d = digit_cnt_q;
        conv_cnt_d  = conv_cnt_q;
        op_valid_d  = op_valid_q;
        op_value_d  = op_value_q;
        op_ovf_d    = op_ovf_q;

        case (state_q)
            ST_ENTRY: begin
                if (key_fire) begin
                    if (key_code_i <= 4'd9) begin
                        // Full buffer and leading zeros are silently dropped
                        if ((digit_cnt_q != 2'(MAX_DIGITS)) &&
                            !((key_code_i == 4'd0) && (digit_cnt_q == 2'd0))) begin
                            bcds_d      = {bcds_q[1], bcds_q[0], key_code_i};
                            digit_cnt_d = digit_cnt_q + 2'd1;
                        end
                    end else begin
                        case (key_code_i)
                            4'hA: negative_d = !negative_q;
                            4'hB: begin
                                state_d    = ST_CONV;
                                conv_cnt_d = CNT_W'(CONV_LAT);
                            end
                            4'hC: begin
                                bcds_d      = '0;
                                negative_d  = 1'b0;
                                digit_cnt_d = 2'd0;
                            end
`ifdef OPERAND_BACKSPACE_EN
                            4'hD: begin
                                if (digit_cnt_q != 2'd0) begin
                                    bcds_d      = {4'd0, bcds_q[2], bcds_q[1]};
                                    digit_cnt_d = digit_cnt_q - 2'd1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end

            ST_CONV: begin
                conv_cnt_d = conv_cnt_q - CNT_W'(1);
                // Counter reaching zero on this edge commits the converter result
                if (conv_cnt_q == CNT_W'(1)) begin
                    op_value_d = conv_value;
                    op_ovf_d   = conv_ovf;
                    op_valid_d = 1'b1;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (op_valid_q && op_ready_i) begin
                    op_valid_d  = 1'b0;
                    bcds_d      = '0;
                    negative_d  = 1'b0;
                    digit_cnt_d = 2'd0;
                    state_d     = ST_ENTRY;
                end
            end

            default: state_d = ST_ENTRY;
        endcase

        key_ready_d = (state_d == ST_ENTRY);
        busy_d      = (state_d != ST_ENTRY);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ENTRY;
            bcds_q      <= '0;
            negative_q  <= 1'b0;
            digit_cnt_q <= 2'd0;
            conv_cnt_q  <= '0;
            op_valid_q  <= 1'b0;
            op_value_q  <= 10'd0;
            op_ovf_q    <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcds_q      <= bcds_d;
            negative_q  <= negative_d;
            digit_cnt_q <= digit_cnt_d;
            conv_cnt_q  <= conv_cnt_d;
            op_valid_q  <= op_valid_d;
            op_value_q  <= op_value_d;
            op_ovf_q    <= op_ovf_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign key_ready_o = key_ready_q;
    assign bcds_o      = bcds_q;
    assign negative_o  = negative_q;
    assign digit_cnt_o = digit_cnt_q;
    assign op_valid_o  = op_valid_q;
    assign op_value_o  = op_value_q;
    assign op_ovf_o    = op_ovf_q;
    assign busy_o      = busy_q;

endmodule
